// File: rtl/water_dispenser_ctrl_pkg.sv
// Shared types and helpers for the water dispenser controller.
package water_dispenser_ctrl_pkg;

  localparam int SWITCH_COUNT = 10;

  typedef enum logic [1:0] {
    ST_READING_INPUT = 2'd0,
    ST_DISPENSING    = 2'd1,
    ST_PAUSED        = 2'd2,
    ST_DONE          = 2'd3
  } state_t;

  // Bits needed to hold 10^digits - 1.
  function automatic int amount_width(input int digits);
    longint p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return $clog2(p);
  endfunction

endpackage

// File: rtl/button_edge_detect.sv
// One-cycle press event on the falling edge of an (already debounced) button.
module button_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic press
);

  logic button_q;

  always_ff @(posedge clock) begin
    if (reset) button_q <= 1'b1;
    else       button_q <= button;
  end

  assign press = button_q & ~button;

endmodule

// File: rtl/water_dispenser_ctrl_dispense_meter.sv
// Flow-pulse accumulation clamped at the requested total, plus the no-flow timer.
module water_dispenser_ctrl_dispense_meter #(
  parameter int AMOUNT_WIDTH   = 14,
  parameter int ML_PER_PULSE   = 1,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    count_en,
  input  logic                    timer_run,
  input  logic                    timer_reload,
  input  logic                    flow_pulse,
  input  logic [AMOUNT_WIDTH-1:0] total,
  output logic [AMOUNT_WIDTH-1:0] dispensed,
  output logic                    reached,
  output logic                    timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int SW = AMOUNT_WIDTH + 8;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [AMOUNT_WIDTH-1:0] dispensed_q;
  logic [TW-1:0]           timer_q;
  logic [SW-1:0]           sum;
  logic                    at_total;

  assign sum      = SW'(dispensed_q) + SW'(ML_PER_PULSE);
  assign at_total = (sum >= SW'(total));
  assign reached  = count_en & flow_pulse & at_total;
  // Down-counter: terminal count 0 equals TIMEOUT_CYCLES-1 idle cycles since load.
  assign timeout  = timer_run & ~flow_pulse & (timer_q == '0);
  assign dispensed = dispensed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      dispensed_q <= '0;
      timer_q     <= TIMER_LOAD;
    end else begin
      if (clear)
        dispensed_q <= '0;
      else if (count_en && flow_pulse)
        dispensed_q <= at_total ? total : sum[AMOUNT_WIDTH-1:0];

      if (clear || timer_reload || (timer_run && flow_pulse))
        timer_q <= TIMER_LOAD;
      else if (timer_run && timer_q != '0)
        timer_q <= timer_q - 1'b1;
    end
  end

endmodule

// File: rtl/water_dispenser_ctrl.sv
// Dispenser controller: keyed volume entry, metering FSM, pause/abort and no-flow fault.
module water_dispenser_ctrl
  import water_dispenser_ctrl_pkg::*;
#(
  parameter int DIGIT_COUNT    = 4,
  parameter int ML_PER_PULSE   = 1,
  parameter int TIMEOUT_CYCLES = 50000000,
  localparam int AMOUNT_WIDTH  = amount_width(DIGIT_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SWITCH_COUNT-1:0] switches,
  input  logic                    button_add,
  input  logic                    button_ok,
  input  logic                    button_cancel,
  input  logic                    flow_pulse,
  output logic [AMOUNT_WIDTH-1:0] total_amount,
  output logic [AMOUNT_WIDTH-1:0] dispensed_amount,
  output logic [2:0]              digit_count,
  output logic                    valve_open,
  output logic [1:0]              state,
  output logic                    done,
  output logic                    fault,
  output logic                    aborted
);

  logic add_press, ok_press, cancel_press;

  button_edge_detect u_add    (.clock(clock), .reset(reset), .button(button_add),    .press(add_press));
  button_edge_detect u_ok     (.clock(clock), .reset(reset), .button(button_ok),     .press(ok_press));
  button_edge_detect u_cancel (.clock(clock), .reset(reset), .button(button_cancel), .press(cancel_press));

  state_t                  state_q, state_d;
  logic [AMOUNT_WIDTH-1:0] total_q, total_d;
  logic [2:0]              digits_q, digits_d;
  logic                    valve_q, done_q, fault_q, fault_d, aborted_q, aborted_d;
  logic                    meter_clear, timer_reload, reached, timeout;
  logic [3:0]              sw_digit;
  logic                    sw_any;

  water_dispenser_ctrl_dispense_meter #(
    .AMOUNT_WIDTH  (AMOUNT_WIDTH),
    .ML_PER_PULSE  (ML_PER_PULSE),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_meter (
    .clock       (clock),
    .reset       (reset),
    .clear       (meter_clear),
    .count_en    (state_q == ST_DISPENSING || state_q == ST_PAUSED),
    .timer_run   (state_q == ST_DISPENSING),
    .timer_reload(timer_reload),
    .flow_pulse  (flow_pulse),
    .total       (total_q),
    .dispensed   (dispensed_amount),
    .reached     (reached),
    .timeout     (timeout)
  );

  // Lowest-index set switch selects the digit.
  always_comb begin
    sw_any   = |switches;
    sw_digit = '0;
    for (int i = SWITCH_COUNT - 1; i >= 0; i--)
      if (switches[i]) sw_digit = 4'(i);
  end

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    digits_d     = digits_q;
    fault_d      = fault_q;
    aborted_d    = aborted_q;
    meter_clear  = 1'b0;
    timer_reload = 1'b0;
    case (state_q)
      ST_READING_INPUT: begin
        if (cancel_press) begin
          total_d  = '0;
          digits_d = '0;
        end else if (ok_press) begin
          if (total_q != '0) begin
            state_d     = ST_DISPENSING;
            meter_clear = 1'b1;
          end
        end else if (add_press && sw_any && digits_q < 3'(DIGIT_COUNT)) begin
          total_d  = AMOUNT_WIDTH'(total_q * AMOUNT_WIDTH'(10) + AMOUNT_WIDTH'(sw_digit));
          digits_d = digits_q + 3'd1;
        end
      end
      ST_DISPENSING: begin
        if (reached)
          state_d = ST_DONE;
        else if (cancel_press)
          state_d = ST_PAUSED;
        else if (timeout) begin
          state_d = ST_DONE;
          fault_d = 1'b1;
        end
      end
      ST_PAUSED: begin
        if (reached)
          state_d = ST_DONE;
        else if (cancel_press) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end else if (ok_press) begin
          state_d      = ST_DISPENSING;
          timer_reload = 1'b1;
        end
      end
      ST_DONE: begin
        if (cancel_press || ok_press) begin
          state_d     = ST_READING_INPUT;
          total_d     = '0;
          digits_d    = '0;
          fault_d     = 1'b0;
          aborted_d   = 1'b0;
          meter_clear = 1'b1;
        end
      end
      default: state_d = ST_READING_INPUT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_READING_INPUT;
      total_q   <= '0;
      digits_q  <= '0;
      valve_q   <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      digits_q  <= digits_d;
      valve_q   <= (state_d == ST_DISPENSING);
      done_q    <= (state_d == ST_DONE) && (state_q != ST_DONE);
      fault_q   <= fault_d;
      aborted_q <= aborted_d;
    end
  end

  assign state        = state_q;
  assign total_amount = total_q;
  assign digit_count  = digits_q;
  assign valve_open   = valve_q;
  assign done         = done_q;
  assign fault        = fault_q;
  assign aborted      = aborted_q;

endmodule
